// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for the iterative divider: issues DIV/DIVU, stalls the
// pipeline until the result returns, writes HI/LO, handles flush and a watchdog.
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_timeout_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_wd_cnt;
  logic          r_start;
  logic          r_signed;
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;
  logic          r_whilo;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_err;

  logic          w_accept;
  logic          w_done;
  logic          w_timeout;
  logic          w_stall;
  logic          w_annul;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_stall     = 1'b0;
    w_annul     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          w_accept    = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        // Flush outranks ready; a result arriving on the last watchdog cycle still lands.
        if (flush_i) begin
          w_annul     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (div_ready_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (r_wd_cnt == CW'(TIMEOUT_CYC)) begin
          w_annul     = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_start  <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_whilo  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_err    <= 1'b0;
    end else begin
      r_start  <= (w_state_nxt == S_WAIT);
      r_whilo  <= w_done;
      r_wd_cnt <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_wd_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_signed <= div_signed_i;
        r_op1    <= reg1_i;
        r_op2    <= reg2_i;
      end
      if (w_done) begin
        r_hi <= div_result_i[63:32];
        r_lo <= div_result_i[31:0];
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Combinational handshakes are held quiet while reset is asserted.
  assign stallreq_o    = w_stall & ~rst;
  assign div_annul_o   = w_annul & ~rst;
  assign div_start_o   = r_start;
  assign div_signed_o  = r_signed;
  assign div_opdata1_o = r_op1;
  assign div_opdata2_o = r_op2;
  assign whilo_o       = r_whilo;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign err_timeout_o = r_err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the divider is played by the stimulus,
// expected values are hand-computed.
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        err_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_issue_ctrl #(.TIMEOUT_CYC(48)) dut (
    .clk           (clk),
    .rst           (rst),
    .div_req_i     (div_req_i),
    .div_signed_i  (div_signed_i),
    .reg1_i        (reg1_i),
    .reg2_i        (reg2_i),
    .flush_i       (flush_i),
    .div_result_i  (div_result_i),
    .div_ready_i   (div_ready_i),
    .div_start_o   (div_start_o),
    .div_annul_o   (div_annul_o),
    .div_signed_o  (div_signed_o),
    .div_opdata1_o (div_opdata1_o),
    .div_opdata2_o (div_opdata2_o),
    .stallreq_o    (stallreq_o),
    .whilo_o       (whilo_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .err_timeout_o (err_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic req, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic rdy,
                       input logic [63:0] res);
    div_req_i    = req;
    div_signed_i = sgn;
    reg1_i       = a;
    reg2_i       = b;
    flush_i      = fl;
    div_ready_i  = rdy;
    div_result_i = res;
    #1;
  endtask

  initial begin
    int stall_cnt;
    int pulses;
    int bad;

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_start", div_start_o, 0);
    check("rst_whilo", whilo_o, 0);
    check("rst_hilo", {hi_o, lo_o}, 64'h0);
    check("rst_err", err_timeout_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: DIVU 100/7, ready in the 33rd WAIT cycle -> 34 stall cycles
    stall_cnt = 0; pulses = 0; bad = 0;
    drive(1, 0, 32'd100, 32'd7, 0, 0, 64'h0);
    check("t1_accept_stall", stallreq_o, 1);
    check("t1_start_pre", div_start_o, 0);
    stall_cnt += int'(stallreq_o);
    @(negedge clk);
    for (int w = 1; w <= 33; w++) begin
      drive(1, 1, 32'hDEAD_0000 + 32'(w), 32'(w), 0, (w == 33),
            (w == 33) ? {32'd2, 32'd14} : 64'hBAD0_BAD0_BAD0_BAD0);
      stall_cnt += int'(stallreq_o);
      pulses    += int'(whilo_o);
      if (div_start_o !== 1'b1 || div_opdata1_o !== 32'd100 ||
          div_opdata2_o !== 32'd7 || div_signed_o !== 1'b0 || div_annul_o !== 1'b0)
        bad++;
      @(negedge clk);
    end
    drive(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 64'h0);
    check("t1_write_whilo", whilo_o, 1);
    check("t1_write_stall", stallreq_o, 0);
    check("t1_write_start", div_start_o, 0);
    check("t1_hi", hi_o, 64'd2);
    check("t1_lo", lo_o, 64'd14);
    stall_cnt += int'(stallreq_o);
    pulses    += int'(whilo_o);
    @(negedge clk);
    check("t1_stall_cycles", stall_cnt, 34);
    check("t1_whilo_pulses", pulses, 1);
    check("t1_operand_hold", bad, 0);

    // Back-to-back: the cycle after WRITE re-issues (DIV -7/2), start still low
    check("b2b_gap_start", div_start_o, 0);
    check("b2b_accept_stall", stallreq_o, 1);
    check("b2b_whilo_clear", whilo_o, 0);
    @(negedge clk);

    // 2: signed op; signedness must hold through WAIT
    bad = 0;
    for (int w = 1; w <= 5; w++) begin
      drive(1, 0, 32'd0, 32'd0, 0, (w == 5), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      if (div_signed_o !== 1'b1 || div_opdata1_o !== 32'hFFFF_FFF9 || stallreq_o !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t2_signed_hold", bad, 0);
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    check("t2_whilo", whilo_o, 1);
    check("t2_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);
    check("t2_whilo_drop", whilo_o, 0);

    // Flush in IDLE blocks the request entirely
    drive(1, 0, 32'd5, 32'd1, 1, 0, 64'h0);
    check("idle_flush_stall", stallreq_o, 0);
    check("idle_flush_annul", div_annul_o, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    check("idle_flush_nostart", div_start_o, 0);
    @(negedge clk);

    // 3: flush on WAIT cycle 10
    drive(1, 0, 32'd1000, 32'd3, 0, 0, 64'h0);
    @(negedge clk);
    bad = 0; pulses = 0;
    for (int w = 1; w <= 10; w++) begin
      drive(1, 0, 32'd1000, 32'd3, (w == 10), 0, 64'h0);
      pulses += int'(whilo_o);
      if (w == 10) begin
        check("t3_annul", div_annul_o, 1);
        check("t3_stall_flush", stallreq_o, 1);
      end else if (div_annul_o !== 1'b0) bad++;
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    pulses += int'(whilo_o);
    check("t3_no_early_annul", bad, 0);
    check("t3_annul_one_cycle", div_annul_o, 0);
    check("t3_stall_after", stallreq_o, 0);
    check("t3_start_after", div_start_o, 0);
    check("t3_no_whilo", pulses, 0);
    check("t3_hilo_kept", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);

    // 4: flush and ready together -> annul wins
    drive(1, 0, 32'd77, 32'd7, 0, 0, 64'h0);
    @(negedge clk);
    for (int w = 1; w <= 3; w++) begin
      drive(1, 0, 32'd77, 32'd7, (w == 3), (w == 3), {32'd0, 32'd11});
      if (w == 3) check("t4_annul", div_annul_o, 1);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    check("t4_no_whilo", whilo_o, 0);
    check("t4_idle_stall", stallreq_o, 0);
    check("t4_start", div_start_o, 0);
    check("t4_hilo_kept", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);

    // 5: divider never answers -> watchdog at WAIT count 48
    drive(1, 0, 32'd9, 32'd0, 0, 0, 64'h0);
    @(negedge clk);
    for (int c = 0; c <= 48; c++) begin
      drive(0, 0, 0, 0, 0, 0, 64'h0);
      if (c == 47) begin
        check("t5_annul_pre", div_annul_o, 0);
        check("t5_err_pre", err_timeout_o, 0);
      end
      if (c == 48) begin
        check("t5_annul", div_annul_o, 1);
        check("t5_stall", stallreq_o, 1);
      end
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    check("t5_err", err_timeout_o, 1);
    check("t5_annul_drop", div_annul_o, 0);
    check("t5_start", div_start_o, 0);
    check("t5_no_whilo", whilo_o, 0);
    @(negedge clk);

    // 6: DIVU 50/5 then DIVU 9/2 back-to-back, reset mid-WAIT of the second
    drive(1, 0, 32'd50, 32'd5, 0, 0, 64'h0);
    @(negedge clk);
    pulses = 0;
    for (int w = 1; w <= 3; w++) begin
      drive(1, 0, 32'd50, 32'd5, 0, (w == 3), {32'd0, 32'd10});
      pulses += int'(whilo_o);
      @(negedge clk);
    end
    drive(1, 0, 32'd9, 32'd2, 0, 0, 64'h0);
    pulses += int'(whilo_o);
    check("t6_first_lo", lo_o, 64'd10);
    check("t6_err_sticky", err_timeout_o, 1);
    @(negedge clk);
    drive(1, 0, 32'd9, 32'd2, 0, 0, 64'h0);
    pulses += int'(whilo_o);
    check("t6_second_accept", stallreq_o, 1);
    @(negedge clk);
    for (int w = 1; w <= 2; w++) begin
      drive(1, 0, 32'd9, 32'd2, 0, 0, 64'h0);
      pulses += int'(whilo_o);
      @(negedge clk);
    end
    check("t6_first_once", pulses, 1);
    check("t6_second_start", div_start_o, 1);
    check("t6_second_op1", div_opdata1_o, 64'd9);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_start", div_start_o, 0);
    check("t6_rst_annul", div_annul_o, 0);
    check("t6_rst_stall", stallreq_o, 0);
    check("t6_rst_ops", {div_opdata1_o, div_opdata2_o}, 64'h0);
    check("t6_rst_signed", div_signed_o, 0);
    check("t6_rst_hilo", {hi_o, lo_o}, 64'h0);
    check("t6_rst_whilo", whilo_o, 0);
    check("t6_rst_err", err_timeout_o, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    check("t6_post_rst_idle", div_start_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
